// File: rtl/cs_gen.sv
// cs_gen: word-granular address window decoder with combinational chip select,
// window-relative word offset, and a one-cycle registered copy of the select.
module cs_gen #(
  parameter logic [31:0] address = 32'h0,
  parameter logic [31:0] size    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] bus_addr,
  output logic        cs,
  output logic        cs_q,
  output logic [29:0] offset
);
  // 33-bit end so a window reaching 2^32 compares correctly instead of wrapping to 0
  localparam logic [32:0] END_B  = {1'b0, address} + {1'b0, size};
  localparam logic [29:0] BASE_W = address[31:2];
  localparam logic [30:0] END_W  = END_B[32:2];
  logic w_hit;
  logic r_cs;
  always_comb begin
    w_hit  = (size != 32'h0) && ({1'b0, bus_addr} >= {1'b0, BASE_W}) && ({1'b0, bus_addr} < END_W);
    cs     = w_hit;
    offset = w_hit ? bus_addr - BASE_W : 30'h0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cs <= 1'b0;
    else        r_cs <= w_hit;
  assign cs_q = r_cs;
endmodule

// File: tb/tb_cs_gen.sv
// tb_cs_gen: directed checks of cs_gen windows, boundaries, empty/full/high windows,
// asynchronous reset of cs_q and cycle-by-cycle cs_q tracking.
module tb_cs_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] bus_addr = 30'h0;
  logic        a_cs, a_csq, z_cs, z_csq, h_cs, h_csq, f_cs, f_csq;
  logic [29:0] a_off, z_off, h_off, f_off;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cs_gen #(.address(32'h8000_0000), .size(32'h1000)) u_a (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .cs(a_cs), .cs_q(a_csq), .offset(a_off));
  cs_gen #(.address(32'h8000_0000), .size(32'h0)) u_z (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .cs(z_cs), .cs_q(z_csq), .offset(z_off));
  cs_gen #(.address(32'hffff_f000), .size(32'h1000)) u_h (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .cs(h_cs), .cs_q(h_csq), .offset(h_off));
  cs_gen #(.address(32'h0), .size(32'hffff_fffc)) u_f (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .cs(f_cs), .cs_q(f_csq), .offset(f_off));

  task automatic test_reset();
    rst_n = 1'b0;
    bus_addr = 30'h2000_0000;
    #1;
    checks++;
    if (a_csq !== 1'b0) begin errors++; $display("FAIL reset_csq got %b want 0", a_csq); end
    checks++;
    if (a_cs !== 1'b1) begin errors++; $display("FAIL reset_cs_valid got %b want 1", a_cs); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_csq !== 1'b0) begin errors++; $display("FAIL reset_hold_csq got %b want 0", a_csq); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_csq !== 1'b1) begin errors++; $display("FAIL reset_release_csq got %b want 1", a_csq); end
  endtask

  task automatic test_window();
    logic [29:0] addrs [4] = '{30'h2000_0000, 30'h2000_03ff, 30'h2000_0400, 30'h1fff_ffff};
    logic        exp_cs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [29:0] exp_off [4] = '{30'h0, 30'h3ff, 30'h0, 30'h0};
    for (int i = 0; i < 4; i++) begin
      bus_addr = addrs[i];
      #1;
      checks++;
      if (a_cs !== exp_cs[i]) begin errors++; $display("FAIL window_cs[%0d] addr %h got %b want %b", i, addrs[i], a_cs, exp_cs[i]); end
      checks++;
      if (a_off !== exp_off[i]) begin errors++; $display("FAIL window_off[%0d] addr %h got %h want %h", i, addrs[i], a_off, exp_off[i]); end
    end
  endtask

  task automatic test_empty();
    logic [29:0] addrs [3] = '{30'h0, 30'h2000_0000, 30'h3fff_ffff};
    for (int i = 0; i < 3; i++) begin
      bus_addr = addrs[i];
      #1;
      checks++;
      if (z_cs !== 1'b0 || z_off !== 30'h0) begin
        errors++; $display("FAIL empty[%0d] addr %h got cs %b off %h want cs 0 off 0", i, addrs[i], z_cs, z_off);
      end
    end
  endtask

  task automatic test_high();
    logic [29:0] addrs [3] = '{30'h3fff_ffff, 30'h3fff_fc00, 30'h3fff_fbff};
    logic        exp_cs [3] = '{1'b1, 1'b1, 1'b0};
    logic [29:0] exp_off [3] = '{30'h3ff, 30'h0, 30'h0};
    for (int i = 0; i < 3; i++) begin
      bus_addr = addrs[i];
      #1;
      checks++;
      if (h_cs !== exp_cs[i] || h_off !== exp_off[i]) begin
        errors++; $display("FAIL high[%0d] addr %h got cs %b off %h want cs %b off %h", i, addrs[i], h_cs, h_off, exp_cs[i], exp_off[i]);
      end
    end
  endtask

  task automatic test_full();
    logic [29:0] addrs [3] = '{30'h0, 30'h3fff_fffe, 30'h3fff_ffff};
    logic        exp_cs [3] = '{1'b1, 1'b1, 1'b0};
    logic [29:0] exp_off [3] = '{30'h0, 30'h3fff_fffe, 30'h0};
    for (int i = 0; i < 3; i++) begin
      bus_addr = addrs[i];
      #1;
      checks++;
      if (f_cs !== exp_cs[i] || f_off !== exp_off[i]) begin
        errors++; $display("FAIL full[%0d] addr %h got cs %b off %h want cs %b off %h", i, addrs[i], f_cs, f_off, exp_cs[i], exp_off[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus_addr = 30'h2000_0100;
    @(negedge clk);
    checks++;
    if (a_csq !== 1'b1) begin errors++; $display("FAIL async_pre_csq got %b want 1", a_csq); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_csq !== 1'b0) begin errors++; $display("FAIL async_csq got %b want 0", a_csq); end
    checks++;
    if (a_cs !== 1'b1) begin errors++; $display("FAIL async_cs got %b want 1", a_cs); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_csq !== 1'b0) begin errors++; $display("FAIL async_release_csq got %b want 0", a_csq); end
    @(negedge clk);
    checks++;
    if (a_csq !== 1'b1) begin errors++; $display("FAIL async_track_csq got %b want 1", a_csq); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] addrs [8] = '{30'h2000_0010, 30'h2000_0400, 30'h2000_03ff, 30'h1fff_ffff,
                               30'h2000_0000, 30'h0, 30'h2000_0001, 30'h3fff_ffff};
    logic        exp_cs [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus_addr = addrs[i];
      @(negedge clk);
      checks++;
      if (a_csq !== exp_cs[i]) begin errors++; $display("FAIL b2b_csq[%0d] got %b want %b", i, a_csq, exp_cs[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_empty();
    test_high();
    test_full();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cs_gen.md
CS_GEN -- requirements
Module: cs_gen

Interface
REQ-001 SHALL have parameter address, default 32'h0, meaning the byte base address of the decoded window.
REQ-002 SHALL have parameter size, default 32'h0, meaning the window length in bytes; 0 means an empty window.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port bus_addr, input, 30 bits: word address, i.e. byte address bits [31:2].
REQ-006 SHALL have port cs, output, 1 bit: combinational chip select for the current bus_addr.
REQ-007 SHALL have port cs_q, output, 1 bit: cs registered by one clk cycle.
REQ-008 SHALL have port offset, output, 30 bits: combinational word offset of bus_addr inside the window.

Function
REQ-009 SHALL compute base word = address[31:2] and end word = (address + size)[32:2], using 33-bit arithmetic so that a window ending at 2^32 does not wrap.
REQ-010 SHALL assert cs iff base word <= bus_addr < end word, compared as unsigned values with the end word zero-extended.
REQ-011 SHALL drive cs low for every bus_addr when size == 0.
REQ-012 SHALL treat address bits [1:0] and size bits [1:0] as ignored; the window is word-granular (truncated).
REQ-013 SHALL make cs purely combinational, with no clock-cycle latency, so that a bus master can register ack from cs in the same cycle as the access.
REQ-014 SHALL keep cs independent of clk and rst_n; it is valid during reset.
REQ-015 SHALL drive offset = bus_addr - base word when cs is high, and 30'b0 otherwise.
REQ-016 SHALL update cs_q <= cs on each rising clk edge; cs_q is one cycle of latency behind cs.
REQ-017 SHALL make cs at the boundaries follow REQ-010 exactly: high at bus_addr == base word, high at end word - 1, low at end word.
REQ-018 SHALL make a window covering the entire space (address = 0, size = 2^32 - 4 or larger) assert cs for all addresses up to its end word.
REQ-019 SHALL NOT contain latches; each output is a pure function of parameters, bus_addr, or the registered state.

Reset
REQ-020 SHALL force cs_q to 0 immediately when rst_n is low, independent of clk.
REQ-021 SHALL hold cs_q at 0 while rst_n is low, and SHALL begin tracking cs at the first rising clk edge after rst_n goes high.
REQ-022 SHALL NOT reset cs or offset; they depend only on bus_addr and the parameters.

Verification
REQ-023 SHALL pass this scenario: address = 32'h8000_0000, size = 32'h1000; bus_addr = 30'h2000_0000 -> cs = 1, offset = 0; bus_addr = 30'h2000_03ff -> cs = 1, offset = 30'h3ff; bus_addr = 30'h2000_0400 -> cs = 0, offset = 0.
REQ-024 SHALL pass this scenario: with the same window, bus_addr = 30'h1fff_ffff -> cs = 0.
REQ-025 SHALL pass this scenario: size = 0, any address parameter, sweep bus_addr across 0, the base word and all-ones -> cs = 0 throughout.
REQ-026 SHALL pass this scenario: address = 32'hffff_f000, size = 32'h1000; bus_addr = 30'h3fff_ffff -> cs = 1, offset = 30'h3ff (no 32-bit wrap).
REQ-027 SHALL pass this scenario: drive bus_addr in-window, then pulse rst_n low mid-cycle -> cs_q = 0 immediately while cs stays 1; release rst_n -> cs_q = 1 after the next rising clk edge.
REQ-028 SHALL pass this scenario: toggle bus_addr in/out of window every cycle -> cs_q equals the previous cycle's cs.
